// File: rtl/note_feeder_if.sv
// rtl/note_feeder_if.sv - control and note-lane bundle between a song controller and note_feeder
//
// Purpose: groups the song control inputs and the note-lane outputs of note_feeder.
// Signals:
//   start, abort      song control strobes (controller -> feeder)
//   mode[2:0]         note density select, latched on start
//   diff[22:0]        step period minus one in clk cycles, latched on start
//   notes1/notes2     32-bit lane patterns, bit 31 oldest, bit 0 newest
//   step              one-cycle pulse on every scroll
//   busy, song_done   song status
// Modports: master = song controller side, slave = note_feeder side.
interface note_feeder_if;
    logic        start;
    logic        abort;
    logic [2:0]  mode;
    logic [22:0] diff;
    logic [31:0] notes1;
    logic [31:0] notes2;
    logic        step;
    logic        busy;
    logic        song_done;

    modport master (
        output start, abort, mode, diff,
        input  notes1, notes2, step, busy, song_done
    );

    modport slave (
        input  start, abort, mode, diff,
        output notes1, notes2, step, busy, song_done
    );
endinterface

// File: rtl/note_feeder.sv
// rtl/note_feeder.sv - pseudo-random two-lane note pattern generator with scrolling
//
// Purpose: produces SONG_LEN LFSR-driven steps, then 32 rest steps that flush both
// lanes, then reports song_done. Step period and note density are latched on start.
// Ports:
//   clk     system clock
//   n_rst   asynchronous active-low reset
//   nf_if   note_feeder_if.slave: start/abort/mode/diff in; notes1/notes2/step/busy/song_done out
// Parameters: SONG_LEN (1..4095 generated steps), SEED (base LFSR seed).
// Optional feature macro: NOTE_FEEDER_MIN_GAP_EN - suppresses a new note whenever the
// previously inserted bit of that lane is 1, so no lane ever carries adjacent notes.
module note_feeder #(
    parameter int          SONG_LEN = 128,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic          clk,
    input  logic          n_rst,
    note_feeder_if.slave  nf_if
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [11:0] LP_LAST_GEN   = 12'(SONG_LEN - 1);
    localparam logic [11:0] LP_FLUSH_STEPS = 12'd32;

    state_t      r_state;
    logic [2:0]  r_mode;
    logic [22:0] r_diff;
    logic [22:0] r_tick;
    logic [11:0] r_cnt;
    logic [15:0] r_lfsr;
    logic [31:0] r_notes1;
    logic [31:0] r_notes2;
    logic        r_step;
    logic        r_busy;
    logic        r_done;

    logic [15:0] w_seed_raw;
    logic [15:0] w_seed;
    logic [4:0]  w_thr;
    logic        w_new1;
    logic        w_new2;
    logic        w_tick_hit;
    logic [15:0] w_lfsr_next;

    // An all-zero seed would lock the LFSR, so fall back to 1.
    assign w_seed_raw = SEED ^ {13'd0, nf_if.mode};
    assign w_seed     = (w_seed_raw == 16'd0) ? 16'h0001 : w_seed_raw;

    assign w_thr       = {1'b0, r_mode, 1'b1};
    assign w_tick_hit  = (r_tick == r_diff);
    // Taps 16,14,13,11 -> bits 15,13,12,10.
    assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

`ifdef NOTE_FEEDER_MIN_GAP_EN
    assign w_new1 = ({1'b0, r_lfsr[3:0]} < w_thr) && !r_notes1[0];
    assign w_new2 = ({1'b0, r_lfsr[7:4]} < w_thr) && !r_notes2[0];
`else
    assign w_new1 = ({1'b0, r_lfsr[3:0]} < w_thr);
    assign w_new2 = ({1'b0, r_lfsr[7:4]} < w_thr);
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= ST_IDLE;
            r_mode   <= 3'd0;
            r_diff   <= 23'd0;
            r_tick   <= 23'd0;
            r_cnt    <= 12'd0;
            r_lfsr   <= 16'd0;
            r_notes1 <= 32'd0;
            r_notes2 <= 32'd0;
            r_step   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (nf_if.abort) begin
                r_state  <= ST_IDLE;
                r_tick   <= 23'd0;
                r_cnt    <= 12'd0;
                r_notes1 <= 32'd0;
                r_notes2 <= 32'd0;
                r_busy   <= 1'b0;
                r_done   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (nf_if.start) begin
                            r_state  <= ST_RUN;
                            r_mode   <= nf_if.mode;
                            r_diff   <= nf_if.diff;
                            r_tick   <= 23'd0;
                            r_cnt    <= 12'd0;
                            r_notes1 <= 32'd0;
                            r_notes2 <= 32'd0;
                            r_lfsr   <= w_seed;
                            r_busy   <= 1'b1;
                            r_done   <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (w_tick_hit) begin
                            r_tick   <= 23'd0;
                            r_step   <= 1'b1;
                            r_notes1 <= {r_notes1[30:0], w_new1};
                            r_notes2 <= {r_notes2[30:0], w_new2};
                            r_lfsr   <= w_lfsr_next;
                            if (r_cnt == LP_LAST_GEN) begin
                                r_state <= ST_FLUSH;
                                r_cnt   <= 12'd0;
                            end else begin
                                r_cnt <= r_cnt + 12'd1;
                            end
                        end else begin
                            r_tick <= r_tick + 23'd1;
                        end
                    end
                    ST_FLUSH: begin
                        // The last flush step is still presented while busy; DONE follows
                        // one cycle later so step never pulses outside RUN/FLUSH.
                        if (r_cnt == LP_FLUSH_STEPS) begin
                            r_state <= ST_DONE;
                            r_tick  <= 23'd0;
                            r_cnt   <= 12'd0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (w_tick_hit) begin
                            r_tick   <= 23'd0;
                            r_step   <= 1'b1;
                            r_notes1 <= {r_notes1[30:0], 1'b0};
                            r_notes2 <= {r_notes2[30:0], 1'b0};
                            r_cnt    <= r_cnt + 12'd1;
                        end else begin
                            r_tick <= r_tick + 23'd1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign nf_if.notes1    = r_notes1;
    assign nf_if.notes2    = r_notes2;
    assign nf_if.step      = r_step;
    assign nf_if.busy      = r_busy;
    assign nf_if.song_done = r_done;
endmodule

// File: tb/tb_note_feeder.sv
// tb/tb_note_feeder.sv - scoreboard testbench for note_feeder
module tb_note_feeder;
    localparam int          SONG_LEN = 128;
    localparam logic [15:0] SEED     = 16'hACE1;
    localparam int          TOTAL    = SONG_LEN + 32;

    logic clk;
    logic n_rst;
    note_feeder_if nf();

    note_feeder #(.SONG_LEN(SONG_LEN), .SEED(SEED)) u_dut (
        .clk   (clk),
        .n_rst (n_rst),
        .nf_if (nf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    logic [63:0] sb_q[$];
    int exp_period;
    int cyc;
    int last_step;
    int steps_seen;
    int ones1;
    bit prev_busy;
    logic [31:0] hold1, hold2;
    bit [SONG_LEN-1:0] seq_cur;
    bit [SONG_LEN-1:0] seq_ref;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every step shifts in one bit per lane; generated bits come from the
    // seeded maximal-length sequence compared against a density threshold.
    task automatic push_song(input logic [2:0] m);
        logic [15:0] l;
        logic [31:0] a, b;
        int thr;
        bit x, y;
        l = SEED ^ {13'd0, m};
        if (l == 16'd0) l = 16'd1;
        thr = 2 * int'(m) + 1;
        a = 32'd0;
        b = 32'd0;
        for (int s = 0; s < TOTAL; s++) begin
            if (s < SONG_LEN) begin
                x = int'(l % 16) < thr;
                y = int'((l / 16) % 16) < thr;
`ifdef NOTE_FEEDER_MIN_GAP_EN
                x = x && !a[0];
                y = y && !b[0];
`endif
                l = {l[14:0], ^(l & 16'hB400)};
            end else begin
                x = 1'b0;
                y = 1'b0;
            end
            a = (a << 1) | 32'(x);
            b = (b << 1) | 32'(y);
            sb_q.push_back({a, b});
        end
    endtask

    // Monitor: pops the scoreboard on every step pulse, checks pacing and hold.
    always @(negedge clk) begin
        if (!n_rst) begin
            prev_busy = 1'b0;
        end else begin
            cyc++;
            if (nf.busy && !prev_busy) begin
                last_step  = cyc;
                steps_seen = 0;
                ones1      = 0;
                hold1      = 32'd0;
                hold2      = 32'd0;
            end
            if (nf.step) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_step", 64'(nf.step), 64'd0);
                end else begin
                    chk("notes_on_step", {nf.notes1, nf.notes2}, sb_q.pop_front());
                    chk("step_interval", 64'(cyc - last_step), 64'(exp_period));
                    chk("busy_on_step", 64'(nf.busy), 64'd1);
                end
                last_step = cyc;
                if (steps_seen < SONG_LEN) begin
                    ones1 += int'(nf.notes1[0]);
                    seq_cur[steps_seen] = nf.notes1[0];
                end
                steps_seen++;
                hold1 = nf.notes1;
                hold2 = nf.notes2;
`ifdef NOTE_FEEDER_MIN_GAP_EN
                chk("min_gap", 64'(nf.notes1[1] & nf.notes1[0] | nf.notes2[1] & nf.notes2[0]), 64'd0);
`endif
            end else if (nf.busy) begin
                chk("hold_between_steps", {nf.notes1, nf.notes2}, {hold1, hold2});
            end
            prev_busy = nf.busy;
        end
    end

    task automatic start_song(input logic [2:0] m, input logic [22:0] d);
        push_song(m);
        exp_period = int'(d) + 1;
        @(posedge clk);
        #1;
        nf.start = 1'b1;
        nf.mode  = m;
        nf.diff  = d;
        @(posedge clk);
        #1;
        nf.start = 1'b0;
        nf.mode  = ~m;                       // mid-song changes must be ignored
        nf.diff  = 23'($urandom_range(0, 7));
    endtask

    task automatic finish_song();
        int budget;
        budget = TOTAL * exp_period + 40;
        for (int i = 0; i < budget && !nf.song_done; i++) @(negedge clk);
        chk("done_timeout", 64'(nf.song_done), 64'd1);
        chk("steps_per_song", 64'(steps_seen), 64'(TOTAL));
        chk("queue_drained", 64'(sb_q.size()), 64'd0);
        chk("done_notes", {nf.notes1, nf.notes2}, 64'd0);
        chk("done_busy", 64'(nf.busy), 64'd0);
        sb_q.delete();
    endtask

    task automatic check_idle(input string name);
        chk(name, {nf.notes1, nf.notes2, 29'd0, nf.step, nf.busy, nf.song_done}, 64'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc = 0;
        last_step = 0;
        steps_seen = 0;
        exp_period = 1;
        nf.start = 1'b0;
        nf.abort = 1'b0;
        nf.mode  = 3'd0;
        nf.diff  = 23'd0;
        n_rst = 1'b0;
        #22;
        check_idle("reset_outputs");
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("idle_after_reset");

        // Pacing: diff=1 -> a step every 2 cycles, 160 steps in total.
        start_song(3'd4, 23'd1);
        finish_song();

        // Density and determinism (second run starts from DONE).
        start_song(3'd7, 23'd0);
        finish_song();
        chk("density_mode7", 64'(ones1 >= 100), 64'd1);
        seq_ref = seq_cur;
        start_song(3'd7, 23'd0);
        finish_song();
        chk("repeat_sequence", 64'(seq_cur), 64'(seq_ref));
        chk("repeat_sequence_hi", 64'(seq_cur >> 64), 64'(seq_ref >> 64));
        start_song(3'd0, 23'd0);
        finish_song();
        chk("density_mode0", 64'(ones1 <= 24), 64'd1);

        for (int k = 0; k < 3; k++) begin
            start_song(3'($urandom_range(0, 7)), 23'($urandom_range(0, 3)));
            finish_song();
        end

        // start during RUN is ignored.
        start_song(3'd2, 23'd2);
        repeat (30) @(posedge clk);
        #1;
        nf.start = 1'b1;
        nf.mode  = 3'd5;
        nf.diff  = 23'd0;
        @(posedge clk);
        #1;
        nf.start = 1'b0;
        finish_song();

        // abort together with start in RUN.
        start_song(3'd6, 23'd1);
        repeat (25) @(posedge clk);
        #1;
        nf.abort = 1'b1;
        nf.start = 1'b1;
        @(posedge clk);
        #1;
        nf.abort = 1'b0;
        nf.start = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check_idle("abort_with_start");
        repeat (10) @(negedge clk);
        check_idle("abort_stays_idle");

        // abort from DONE clears song_done.
        start_song(3'd1, 23'd0);
        finish_song();
        @(posedge clk);
        #1;
        nf.abort = 1'b1;
        @(posedge clk);
        #1;
        nf.abort = 1'b0;
        @(negedge clk);
        check_idle("abort_from_done");

        // Asynchronous reset in the middle of a song.
        start_song(3'd3, 23'd0);
        repeat (40) @(negedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check_idle("async_reset_mid_song");
        sb_q.delete();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
        check_idle("idle_after_mid_reset");

        // A fresh song after reset still matches the model.
        start_song(3'd5, 23'd1);
        finish_song();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
